// File: rtl/regfile_dump_reader.sv
// Walks the register file in ascending order and streams each entry out on a valid/ready port.
// Define SKIP_XZR_EN to leave out the top (hard-wired zero) register.
module regfile_dump_reader #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             busy,
  output logic             done
);

`ifdef SKIP_XZR_EN
  localparam logic [AW-1:0] LAST = AW'(NREGS - 2);
`else
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  state_t           stateNext;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addrNext;
  logic             validNext;
  logic [WIDTH-1:0] dataNext;
  logic [AW-1:0]    outAddrNext;
  logic             doneNext;
  logic             load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      addr      <= addrNext;
      out_valid <= validNext;
      out_data  <= dataNext;
      out_addr  <= outAddrNext;
      done      <= doneNext;
    end
  end

  // The output slot refills whenever it is empty or being emptied this cycle, so a
  // stalled consumer freezes the address counter and the held entry together.
  always_comb begin
    stateNext   = state;
    addrNext    = addr;
    validNext   = out_valid;
    dataNext    = out_data;
    outAddrNext = out_addr;
    doneNext    = 1'b0;
    load        = !out_valid || out_ready;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          addrNext  = '0;
        end
      end
      RUN: begin
        if (load) begin
          dataNext    = rd_data;
          outAddrNext = addr;
          validNext   = 1'b1;
          if (addr == LAST) begin
            stateNext = DRAIN;
          end else begin
            addrNext = addr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          validNext = 1'b0;
          doneNext  = 1'b1;
          addrNext  = '0;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        addrNext  = '0;
      end
    endcase
  end

  assign rd_addr = addr;
  assign busy    = (state != IDLE);

endmodule
